// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780 8-bit byte write engine (RS/E/DB timing + waits).
// Optional macro LCD_PWRUP_DELAY_EN adds a power-up hold state after reset.
module lcd_write_engine #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_HIGH_CYC    = 12,
  parameter int unsigned WAIT_REF_CYC  = 2000,
  parameter int unsigned WAIT_INIT_CYC = 205000,
  parameter int unsigned PWRUP_CYC     = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enable,
  input  logic       mode,
  input  logic [1:0] lcd_cnt,
  input  logic       reg_sel,
  input  logic [7:0] din,
  output logic [1:0] byte_idx,
  output logic       busy,
  output logic       lcd_finish,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  // every delay must be nonzero and fit the shared 20-bit counter
  if (SETUP_CYC < 2 || E_HIGH_CYC < 1 ||
      WAIT_REF_CYC < 1 || WAIT_INIT_CYC < 1 ||
      PWRUP_CYC < 1 ||
      WAIT_REF_CYC > 1048576 ||
      WAIT_INIT_CYC > 1048576 ||
      PWRUP_CYC > 1048576) begin : g_bad_cfg
    $error("lcd_write_engine: delay parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EHIGH,
    S_WAIT,
    S_DONE
`ifdef LCD_PWRUP_DELAY_EN
    , S_PWRUP
`endif
  } state_t;

  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EHIGH_LD = 20'(E_HIGH_CYC - 1);
  localparam logic [19:0] REF_LD   = 20'(WAIT_REF_CYC - 1);
  localparam logic [19:0] INIT_LD  = 20'(WAIT_INIT_CYC - 1);

`ifdef LCD_PWRUP_DELAY_EN
  localparam state_t      RST_STATE = S_PWRUP;
  localparam logic [19:0] RST_DLY   = 20'(PWRUP_CYC - 1);
`else
  localparam state_t      RST_STATE = S_IDLE;
  localparam logic [19:0] RST_DLY   = 20'd0;
`endif

  state_t      state_q, state_d;
  logic [19:0] dly_q, dly_d;
  logic [1:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsl_q, rsl_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  db_q, db_d;
  logic        fin_q, fin_d;
  logic        busy_q, busy_d;
  logic        dly_zero;
`ifdef LCD_PWRUP_DELAY_EN
  logic        pend_q, pend_d;
`endif

  assign dly_zero = (dly_q == 20'd0);

  // next-state and next-output logic for the write sequencer
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rsl_d   = rsl_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    fin_d   = 1'b0;
`ifdef LCD_PWRUP_DELAY_EN
    pend_d  = pend_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef LCD_PWRUP_DELAY_EN
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_SETUP;
          dly_d   = SETUP_LD;
          idx_d   = 2'd0;
          rs_d    = rsl_q;
        end else
`endif
        if (lcd_enable) begin
          mode_d  = mode;
          cnt_d   = lcd_cnt;
          rsl_d   = reg_sel;
          state_d = S_SETUP;
          dly_d   = SETUP_LD;
          idx_d   = 2'd0;
          rs_d    = reg_sel;
        end
      end
`ifdef LCD_PWRUP_DELAY_EN
      S_PWRUP: begin
        if (lcd_enable) begin
          mode_d = mode;
          cnt_d  = lcd_cnt;
          rsl_d  = reg_sel;
          pend_d = 1'b1;
        end
        if (dly_zero) state_d = S_IDLE;
        else          dly_d   = dly_q - 20'd1;
      end
`endif
      S_SETUP: begin
        if (dly_q == SETUP_LD) db_d = din;
        if (dly_zero) begin
          state_d = S_EHIGH;
          dly_d   = EHIGH_LD;
          e_d     = 1'b1;
        end else begin
          dly_d   = dly_q - 20'd1;
        end
      end
      S_EHIGH: begin
        if (dly_zero) begin
          state_d = S_WAIT;
          dly_d   = mode_q ? INIT_LD : REF_LD;
          e_d     = 1'b0;
        end else begin
          dly_d   = dly_q - 20'd1;
        end
      end
      S_WAIT: begin
        if (!dly_zero) begin
          dly_d = dly_q - 20'd1;
        end else if (idx_q == cnt_q) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
          rs_d    = 1'b0;
        end else begin
          state_d = S_SETUP;
          dly_d   = SETUP_LD;
          idx_d   = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef LCD_PWRUP_DELAY_EN
    busy_d = (state_d != S_IDLE) || pend_d;
`else
    busy_d = (state_d != S_IDLE);
`endif
  end

  // state, counter and registered panel outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      dly_q   <= RST_DLY;
      idx_q   <= 2'd0;
      mode_q  <= 1'b0;
      cnt_q   <= 2'd0;
      rsl_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LCD_PWRUP_DELAY_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rsl_q   <= rsl_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
`ifdef LCD_PWRUP_DELAY_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign byte_idx   = idx_q;
  assign busy       = busy_q;
  assign lcd_finish = fin_q;
  assign lcd_e      = e_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_db     = db_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: table-driven and random checks of lcd_write_engine.
// Expected timing comes from per-byte arithmetic, not from the RTL states.
module tb_lcd_write_engine;

  localparam int SETUP = 2;
  localparam int EH    = 3;
  localparam int WREF  = 5;
  localparam int WINIT = 20;
  localparam int PWR   = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_enable = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] lcd_cnt = 2'd0;
  logic       reg_sel = 1'b0;
  logic [7:0] din;
  logic [1:0] byte_idx;
  logic       busy, lcd_finish, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
  logic [7:0] tab [4];

  assign din = tab[byte_idx];

  lcd_write_engine #(
    .SETUP_CYC    (SETUP),
    .E_HIGH_CYC   (EH),
    .WAIT_REF_CYC (WREF),
    .WAIT_INIT_CYC(WINIT),
    .PWRUP_CYC    (PWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_enable(lcd_enable),
    .mode      (mode),
    .lcd_cnt   (lcd_cnt),
    .reg_sel   (reg_sel),
    .din       (din),
    .byte_idx  (byte_idx),
    .busy      (busy),
    .lcd_finish(lcd_finish),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db    (lcd_db)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] db;
    logic       rs;
  } rise_t;

  rise_t rises[$];
  int    widths[$];
  int    fin_t[$];
  int    rise_at = 0;
  int    rw_bad = 0;
  logic  e_prev = 1'b0;

  always @(negedge clk) begin
    rise_t r;
    if (lcd_e && !e_prev) begin
      r.t  = cyc;
      r.db = lcd_db;
      r.rs = lcd_rs;
      rises.push_back(r);
      rise_at = cyc;
    end
    if (!lcd_e && e_prev) widths.push_back(cyc - rise_at);
    if (lcd_finish) fin_t.push_back(cyc);
    if (lcd_rw !== 1'b0) rw_bad++;
    e_prev = lcd_e;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fill_tab(input logic [7:0] base);
    for (int k = 0; k < 4; k++) tab[k] = base + 8'(k);
  endtask

  task automatic clear_mon();
    rises.delete();
    widths.delete();
    fin_t.delete();
  endtask

  task automatic drive_start(input logic m, input logic [1:0] c,
                             input logic r, output int t_drv);
    @(posedge clk); #1;
    clear_mon();
    mode = m;
    lcd_cnt = c;
    reg_sel = r;
    lcd_enable = 1'b1;
    t_drv = cyc;
    @(posedge clk); #1;
    lcd_enable = 1'b0;
    mode = 1'($urandom);
    lcd_cnt = 2'($urandom);
    reg_sel = 1'($urandom);
  endtask

  // reference: each byte takes SETUP+EH+wait cycles after acceptance
  task automatic wait_and_check(input int t_acc, input logic m,
                                input logic [1:0] c, input logic r,
                                input int exp_lat, input int t_drv,
                                input bit b2b, output int t_fin);
    int per;
    int nb;
    per = SETUP + EH + (m ? WINIT : WREF);
    nb = int'(c) + 1;
    t_fin = -1;
    for (int i = 0; i < nb * per + 30; i++) begin
      @(negedge clk);
      if (lcd_finish) begin
        t_fin = cyc;
        break;
      end
    end
    chk("finish_seen", t_fin >= 0, 1);
    if (t_fin < 0) return;
    chk("finish_time", t_fin, t_acc + nb * per);
    if (exp_lat >= 0) chk("finish_latency", t_fin - t_drv, exp_lat);
    chk("finish_rs", lcd_rs, 0);
    chk("finish_db", lcd_db, tab[c]);
    chk("finish_idx", byte_idx, c);
    chk("finish_busy", busy, 1);
    chk("pulse_count", rises.size(), nb);
    chk("width_count", widths.size(), nb);
    for (int k = 0; k < nb && k < rises.size(); k++) begin
      chk("rise_time", rises[k].t, t_acc + SETUP + k * per);
      chk("rise_db", rises[k].db, tab[k]);
      chk("rise_rs", rises[k].rs, r);
    end
    for (int k = 0; k < nb && k < widths.size(); k++)
      chk("e_width", widths[k], EH);
    if (!b2b) begin
      repeat (2) @(negedge clk);
      chk("finish_pulses", fin_t.size(), 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic noise();
    for (int i = 0; i < 200 && !lcd_e; i++) @(negedge clk);
    @(posedge clk); #1;
    lcd_enable = 1'b1;
    mode = ~mode;
    lcd_cnt = 2'd3;
    reg_sel = ~reg_sel;
    @(posedge clk); #1;
    lcd_enable = 1'b0;
    for (int i = 0; i < 200 && lcd_e; i++) @(negedge clk);
    @(posedge clk); #1;
    lcd_enable = 1'b1;
    @(posedge clk); #1;
    lcd_enable = 1'b0;
  endtask

  typedef struct {
    logic       m;
    logic [1:0] c;
    logic       r;
    logic [7:0] base;
    bit         nz;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int td, tf, tf2, t_acc, nb_pre, nb_up, t_rise, n;
    logic was;
    logic m;
    logic [1:0] c;
    logic r;
    bit b2b;

    vecs[0] = '{1'b0, 2'd3, 1'b1, 8'h41, 1'b0, 41};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 8'h38, 1'b0, 26};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 11};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 8'h10, 1'b0, 51};
    vecs[4] = '{1'b0, 2'd1, 1'b1, 8'h70, 1'b1, 21};

    fill_tab(8'h5A);
    repeat (3) @(negedge clk);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_db", lcd_db, 0);
    chk("rst_finish", lcd_finish, 0);
    chk("rst_idx", byte_idx, 0);
    chk("rst_busy", busy, 0);

    // start pulse five cycles after reset release
    rst = 1'b1;
    clear_mon();
    nb_pre = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!busy) nb_pre++;
    end
    mode = 1'b0;
    lcd_cnt = 2'd0;
    reg_sel = 1'b1;
    lcd_enable = 1'b1;
    @(negedge clk);
    lcd_enable = 1'b0;
    mode = 1'b1;
    lcd_cnt = 2'd3;
    reg_sel = 1'b0;
`ifdef LCD_PWRUP_DELAY_EN
    chk("pre_start_busy_low", nb_pre, 0);
    t_acc = PWR + 1;
`else
    chk("pre_start_busy_low", nb_pre, 5);
    t_acc = 6;
`endif
    nb_up = 0;
    t_rise = -1;
    for (int i = 0; i < 120; i++) begin
      if (lcd_e) begin
        t_rise = cyc;
        break;
      end
      if (!busy && cyc > 6) nb_up++;
      @(negedge clk);
    end
`ifdef LCD_PWRUP_DELAY_EN
    chk("first_rise_cycle", t_rise, PWR + 1 + SETUP);
`else
    chk("first_rise_cycle", t_rise, 5 + 1 + SETUP);
`endif
    chk("busy_until_rise", nb_up, 0);
    wait_and_check(t_acc, 1'b0, 2'd0, 1'b1, -1, 0, 1'b0, tf);

    // table vectors, last one with ignored pulses during EHIGH and WAIT
    foreach (vecs[v]) begin
      fill_tab(vecs[v].base);
      drive_start(vecs[v].m, vecs[v].c, vecs[v].r, td);
      if (vecs[v].nz) begin
        fork
          noise();
        join_none
      end
      wait_and_check(td + 1, vecs[v].m, vecs[v].c, vecs[v].r,
                     vecs[v].lat, td, 1'b0, tf);
    end

    // back-to-back: start in the cycle after lcd_finish
    fill_tab(8'hC0);
    drive_start(1'b0, 2'd1, 1'b1, td);
    wait_and_check(td + 1, 1'b0, 2'd1, 1'b1, 21, td, 1'b1, tf);
    fill_tab(8'h20);
    drive_start(1'b1, 2'd2, 1'b0, td);
    chk("b2b_gap", td - tf, 1);
    wait_and_check(td + 1, 1'b1, 2'd2, 1'b0, 76, td, 1'b0, tf2);

    // reset during second byte's E-high phase
    fill_tab(8'h11);
    drive_start(1'b0, 2'd3, 1'b1, td);
    n = 0;
    was = 1'b0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (lcd_e && !was) n++;
      was = lcd_e;
    end
    chk("second_rise_seen", n, 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_rs", lcd_rs, 0);
    chk("mid_rst_db", lcd_db, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", byte_idx, 0);
    chk("mid_rst_finish", lcd_finish, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fin_t.delete();
`ifdef LCD_PWRUP_DELAY_EN
    repeat (PWR + 60) @(negedge clk);
`else
    repeat (60) @(negedge clk);
`endif
    chk("no_finish_after_rst", fin_t.size(), 0);
    chk("idle_after_rst", busy, 0);
    fill_tab(8'h61);
    drive_start(1'b0, 2'd2, 1'b1, td);
    wait_and_check(td + 1, 1'b0, 2'd2, 1'b1, 31, td, 1'b0, tf);

    // randomized transfers against the arithmetic model
    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom);
      c = 2'($urandom);
      r = 1'($urandom);
      b2b = (t != 23) && ($urandom_range(0, 1) == 1);
      fill_tab(8'($urandom));
      drive_start(m, c, r, td);
      wait_and_check(td + 1, m, c, r, -1, td, b2b, tf);
    end

    chk("lcd_rw_always_zero", rw_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Byte-level HD44780 write engine that answers the LCD main controller's handshake. On a one-cycle `lcd_enable` start pulse it writes `lcd_cnt`+1 bytes to the panel over the 8-bit bus, generating RS/E/DB timing and command-execution waits, then returns a one-cycle `lcd_finish`. It sits between the main controller/data mux and the LCD pins.

## Interface
- `SETUP_CYC`, 2: cycles RS/DB held with E low before E rises (≥2).
- `E_HIGH_CYC`, 12: E high width in cycles (≥1).
- `WAIT_REF_CYC`, 2000: post-byte wait in refresh mode (40 µs @ 50 MHz).
- `WAIT_INIT_CYC`, 205000: post-byte wait in init mode (4.1 ms @ 50 MHz).
- `PWRUP_CYC`, 750000: power-up delay (15 ms @ 50 MHz), used only with the macro.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `lcd_enable` in 1: start pulse from controller.
- `mode` in 1: 1 = init (long wait), 0 = refresh (short wait); latched at start.
- `lcd_cnt` in 2: bytes to write minus 1; latched at start.
- `reg_sel` in 1: RS value for the whole transfer; latched at start.
- `din` in 8: byte for current `byte_idx`, from external mux, combinational on `byte_idx`.
- `byte_idx` out 2: index of byte being written.
- `busy` out 1: high in every state except IDLE.
- `lcd_finish` out 1: one-cycle transfer-complete pulse.
- `lcd_e`, `lcd_rs`, `lcd_rw` out 1 each: panel strobes; `lcd_rw` constant 0.
- `lcd_db` out 8: panel data bus.

## Operation
- All outputs registered. Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_db`=8'h00, `lcd_finish`=0, `byte_idx`=0, `busy`=0; state IDLE (PWRUP with macro); delay counter 0; pending flag 0.
- One 20-bit down-counter serves all delays; each phase loads N-1 and leaves when it reads 0, so a phase lasts exactly N cycles.
- States: IDLE, PWRUP, SETUP, EHIGH, WAIT, DONE.
- IDLE: `lcd_enable`=1 latches `mode`, `lcd_cnt`, `reg_sel`, sets `byte_idx`=0 -> SETUP.
- SETUP (`SETUP_CYC` cycles): `lcd_e`=0, `lcd_rs`=latched RS; `lcd_db`<=`din` at end of first SETUP cycle -> EHIGH.
- EHIGH (`E_HIGH_CYC` cycles): `lcd_e`=1; RS, DB frozen -> WAIT.
- WAIT (`WAIT_INIT_CYC` if latched mode=1 else `WAIT_REF_CYC`): `lcd_e`=0, RS/DB held. At end: if `byte_idx`==latched cnt -> DONE, else `byte_idx`+1 -> SETUP.
- DONE: `lcd_finish`=1 one cycle -> IDLE; `lcd_rs` returns 0, `lcd_db` holds last byte.
- `lcd_enable` outside IDLE/PWRUP is ignored; inputs changing mid-transfer have no effect.
- `byte_idx` never wraps: max 3, cleared only at start or reset.

## Timing
- Start to first E rise: 1 + `SETUP_CYC` cycles after the accepting edge.
- Per byte: `SETUP_CYC`+`E_HIGH_CYC`+wait cycles; total latency start->`lcd_finish` = 1 + (cnt+1)·(per-byte) cycles.
- `lcd_finish` high exactly one cycle; next `lcd_enable` accepted the following cycle (IDLE).
- Reset assertion mid-transfer: outputs go to reset values immediately (E drops asynchronously); no `lcd_finish`.

## Configuration
- `LCD_PWRUP_DELAY_EN` defined: after reset, state PWRUP for `PWRUP_CYC` cycles, `busy`=1, panel outputs at reset values; a `lcd_enable` pulse seen during PWRUP sets a pending flag and the transfer starts (latching inputs sampled with that pulse) in the cycle after PWRUP ends.
- Undefined: reset enters IDLE directly; PWRUP state and pending flag absent.

## Test plan
(Bench overrides: SETUP_CYC=2, E_HIGH_CYC=3, WAIT_REF_CYC=5, WAIT_INIT_CYC=20, PWRUP_CYC=50.)
- Refresh, cnt=3, RS=1, din=8'h41+idx -> four E pulses of 3 cycles, DB 41,42,43,44, RS=1 throughout, `lcd_finish` one cycle 41 cycles after start.
- Init, cnt=0, RS=0, din=8'h38 -> one E pulse, DB=38, `lcd_finish` 26 cycles after start.
- `lcd_enable` pulses during EHIGH and WAIT -> ignored, byte count and finish timing unchanged.
- `rst` low during second byte's EHIGH -> `lcd_e`=0 same cycle, all outputs reset, no finish; new start after release works normally.
- Start pulse in cycle after `lcd_finish` -> accepted, second transfer runs with new latched values.
- Macro defined, `lcd_enable` at cycle 5 after reset -> first E rise at cycle 50+1+2, `busy`=1 throughout; macro undefined -> E rise at cycle 5+1+2.
